// File: rtl/cu_pkg.sv
// Shared definitions for the Mini-SRC hardwired control unit: opcodes,
// sequencer states, instruction classes and the control-strobe bundle.
package cu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT, S_PAUSE
  } state_e;

  typedef enum logic [3:0] {
    C_ALU_R, C_ALU_I, C_UNARY, C_MULDIV, C_LD, C_LDI, C_ST, C_NOP, C_HALT
  } cls_e;

  // One bit per datapath control line, plus the Run status.
  typedef struct packed {
    logic pc_out;
    logic zhi_out;
    logic zlo_out;
    logic mdr_out;
    logic c_out;
    logic ba_out;
    logic pc_in;
    logic mar_in;
    logic mdr_in;
    logic ir_in;
    logic y_in;
    logic z_in;
    logic hi_in;
    logic lo_in;
    logic r_in;
    logic r_out;
    logic gra;
    logic grb;
    logic grc;
    logic inc_pc;
    logic read;
    logic write;
    logic run;
  } ctrl_t;

endpackage

// File: rtl/cu_decode.sv
// Opcode classifier: maps IR[31:27] to an instruction class and the
// function code the ALU should see during the instruction's ALU step.
module cu_decode
  import cu_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0] op,
  output cls_e           cls,
  output logic [OPW-1:0] alu_op
);

  // Address and immediate-load calculations reuse the adder; unknown opcodes fall to nop.
  always_comb begin
    cls    = C_NOP;
    alu_op = '0;
    if (op >= OP_ADD && op <= OP_ROL) begin
      cls    = C_ALU_R;
      alu_op = op;
    end else if (op >= OP_ADDI && op <= OP_ORI) begin
      cls    = C_ALU_I;
      alu_op = op;
    end else if (op == OP_MUL || op == OP_DIV) begin
      cls    = C_MULDIV;
      alu_op = op;
    end else if (op == OP_NEG || op == OP_NOT) begin
      cls    = C_UNARY;
      alu_op = op;
    end else if (op == OP_LD) begin
      cls    = C_LD;
      alu_op = OP_ADD;
    end else if (op == OP_LDI) begin
      cls    = C_LDI;
      alu_op = OP_ADD;
    end else if (op == OP_ST) begin
      cls    = C_ST;
      alu_op = OP_ADD;
    end else if (op == OP_HALT) begin
      cls = C_HALT;
    end
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the Mini-SRC datapath: common fetch T0-T2,
// class-specific execute T3-T7, memory-wait steps, halt and pause.
module control_unit
  import cu_pkg::*;
#(
  parameter int OPW = 5,
  parameter int AW  = 4
) (
  input  logic           Clock,
  input  logic           Clear,
  input  logic [31:0]    IR,
  input  logic           Mem_done,
  input  logic           Stop,
  output logic           PCout,
  output logic           Zhighout,
  output logic           Zlowout,
  output logic           MDRout,
  output logic           Cout,
  output logic           BAout,
  output logic           PCin,
  output logic           MARin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Yin,
  output logic           Zin,
  output logic           HIin,
  output logic           LOin,
  output logic           Rin,
  output logic           Rout,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           IncPC,
  output logic           Read,
  output logic           Write,
  output logic [OPW-1:0] Alu_op,
  output logic           Run
);

  // Register fields are steered by Gra/Grb/Grc in the datapath, not here.
  localparam int RC_LSB = 32 - OPW - 3 * AW;

  state_e         state_q, state_d, end_st;
  cls_e           cls;
  logic [OPW-1:0] dec_alu;
  ctrl_t          c;
  logic           unused_fields;

  assign unused_fields = ^{IR[31-OPW:RC_LSB], IR[RC_LSB-1:0]};

  cu_decode #(.OPW(OPW)) u_decode (
    .op     (IR[31:32-OPW]),
    .cls    (cls),
    .alu_op (dec_alu)
  );

  // Next-state: memory steps hold until Mem_done; Stop is looked at only when an instruction ends.
  always_comb begin
    end_st  = Stop ? S_PAUSE : S_T0;
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = Mem_done ? S_T2 : S_T1;
      S_T2:    state_d = S_T3;
      S_T3: begin
        case (cls)
          C_HALT:  state_d = S_HALT;
          C_NOP:   state_d = end_st;
          default: state_d = S_T4;
        endcase
      end
      S_T4:    state_d = (cls == C_UNARY) ? end_st : S_T5;
      S_T5: begin
        case (cls)
          C_ALU_R, C_ALU_I, C_LDI: state_d = end_st;
          C_MULDIV, C_LD, C_ST:    state_d = S_T6;
          default:                 state_d = S_T0;
        endcase
      end
      S_T6: begin
        case (cls)
          C_MULDIV: state_d = end_st;
          C_LD:     state_d = Mem_done ? S_T7 : S_T6;
          C_ST:     state_d = S_T7;
          default:  state_d = S_T0;
        endcase
      end
      S_T7: begin
        case (cls)
          C_LD:    state_d = end_st;
          C_ST:    state_d = Mem_done ? end_st : S_T7;
          default: state_d = S_T0;
        endcase
      end
      S_HALT:  state_d = S_HALT;
      S_PAUSE: state_d = Stop ? S_PAUSE : S_T0;
      default: state_d = S_RESET;
    endcase
  end

  // State register; Clear forces RESET at once, mid-wait included.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) state_q <= S_RESET;
    else        state_q <= state_d;
  end

  // Output decode from the state register (IR is itself a held register).
  always_comb begin
    c      = '0;
    Alu_op = '0;
    case (state_q)
      S_T0: begin
        c.run = 1'b1; c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1;
      end
      S_T1: begin
        c.run = 1'b1; c.zlo_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1;
      end
      S_T2: begin
        c.run = 1'b1; c.mdr_out = 1'b1; c.ir_in = 1'b1;
      end
      S_T3: begin
        c.run = 1'b1;
        case (cls)
          C_ALU_R, C_ALU_I: begin c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
          C_UNARY: begin
            c.grb = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1; Alu_op = dec_alu;
          end
          C_MULDIV:         begin c.gra = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
          C_LD, C_LDI, C_ST: begin c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        c.run = 1'b1;
        case (cls)
          C_ALU_R: begin
            c.grc = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1; Alu_op = dec_alu;
          end
          C_ALU_I, C_LD, C_LDI, C_ST: begin
            c.c_out = 1'b1; c.z_in = 1'b1; Alu_op = dec_alu;
          end
          C_UNARY: begin c.zlo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
          C_MULDIV: begin
            c.grb = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1; Alu_op = dec_alu;
          end
          default: ;
        endcase
      end
      S_T5: begin
        c.run = 1'b1;
        case (cls)
          C_ALU_R, C_ALU_I, C_LDI: begin c.zlo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
          C_MULDIV:                begin c.zlo_out = 1'b1; c.lo_in = 1'b1; end
          C_LD, C_ST:              begin c.zlo_out = 1'b1; c.mar_in = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        c.run = 1'b1;
        case (cls)
          C_MULDIV: begin c.zhi_out = 1'b1; c.hi_in = 1'b1; end
          C_LD:     begin c.read = 1'b1; c.mdr_in = 1'b1; end
          C_ST:     begin c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1; end
          default: ;
        endcase
      end
      S_T7: begin
        c.run = 1'b1;
        case (cls)
          C_LD:    begin c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
          C_ST:    c.write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign PCout    = c.pc_out;
  assign Zhighout = c.zhi_out;
  assign Zlowout  = c.zlo_out;
  assign MDRout   = c.mdr_out;
  assign Cout     = c.c_out;
  assign BAout    = c.ba_out;
  assign PCin     = c.pc_in;
  assign MARin    = c.mar_in;
  assign MDRin    = c.mdr_in;
  assign IRin     = c.ir_in;
  assign Yin      = c.y_in;
  assign Zin      = c.z_in;
  assign HIin     = c.hi_in;
  assign LOin     = c.lo_in;
  assign Rin      = c.r_in;
  assign Rout     = c.r_out;
  assign Gra      = c.gra;
  assign Grb      = c.grb;
  assign Grc      = c.grc;
  assign IncPC    = c.inc_pc;
  assign Read     = c.read;
  assign Write    = c.write;
  assign Run      = c.run;

endmodule
